input_vc_unit: RTL and testbench

//  Per-input-port front end of the router, directly upstream of allocator_separable.

---
 rtl/vcr_pkg.sv | 27 ++
 rtl/vc_fifo.sv | 56 +++++
 rtl/input_vc_unit.sv | 182 ++++++++++++++++++
 tb/tb_input_vc_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vcr_pkg.sv
// Router-wide types and flit field helpers shared by the input unit, allocator and crossbar.
package vcr_pkg;

  localparam int TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    FLIT_BODY      = 2'b00,
    FLIT_HEAD      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    VC_IDLE   = 2'd0,
    VC_ROUTE  = 2'd1,
    VC_ACTIVE = 2'd2
  } vc_state_e;

  function automatic logic is_head(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_HEAD_TAIL);
  endfunction

  function automatic logic is_tail(input flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit buffer; the front entry is exposed combinationally so the
// VC state machine can inspect the head flit without an extra cycle.
module vc_fifo #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [FLIT_W-1:0]        push_flit,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [FLIT_W-1:0]        front
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign front   = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  // A full buffer still takes a write when the same edge frees a slot.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_flit;
  end

endmodule

// File: rtl/input_vc_unit.sv
// Router input port: per-VC buffering, head-flit route latch, switch-allocation requests,
// grant-driven dequeue to the crossbar and upstream credit return.
module input_vc_unit
  import vcr_pkg::*;
#(
  parameter int NUM_VCS  = 4,
  parameter int NUM_OUTS = 3,
  parameter int DEPTH    = 4,
  parameter int FLIT_W   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [$clog2(NUM_VCS)-1:0]    in_vc,
  input  logic [FLIT_W-1:0]             in_flit,
  output logic [NUM_VCS*NUM_OUTS-1:0]   sa_req,
  input  logic [NUM_VCS-1:0]            sa_grant,
  output logic                          out_valid,
  output logic [$clog2(NUM_OUTS)-1:0]   out_port,
  output logic [FLIT_W-1:0]             out_flit,
  output logic                          credit_valid,
  output logic [$clog2(NUM_VCS)-1:0]    credit_vc,
  output logic                          err
);

  localparam int VC_W  = $clog2(NUM_VCS);
  localparam int OUT_W = $clog2(NUM_OUTS);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  vc_state_e         state_reg  [NUM_VCS];
  vc_state_e         state_next [NUM_VCS];
  logic [OUT_W-1:0]  route_reg  [NUM_VCS];
  logic [OUT_W-1:0]  route_next [NUM_VCS];
  logic [FLIT_W-1:0] fifo_front [NUM_VCS];
  logic [CNT_W-1:0]  fifo_count [NUM_VCS];

  logic [NUM_VCS-1:0] fifo_push;
  logic [NUM_VCS-1:0] fifo_pop;
  logic [NUM_VCS-1:0] fifo_full;
  logic [NUM_VCS-1:0] fifo_empty;
  logic [NUM_VCS-1:0] requesting;
  logic [NUM_VCS-1:0] head_front;
  logic [NUM_VCS-1:0] tail_front;
  logic [NUM_VCS-1:0] bad_dest;
  logic [NUM_VCS-1:0] discard_cand;

  logic            grant_any;
  logic            grant_multi;
  logic            grant_pop;
  logic            grant_bad;
  logic [VC_W-1:0] grant_vc;
  logic            pop_any;
  logic [VC_W-1:0] pop_vc;
  logic            route_err;
  logic            drop_any;

  logic              out_valid_reg;
  logic [OUT_W-1:0]  out_port_reg;
  logic [FLIT_W-1:0] out_flit_reg;
  logic              credit_valid_reg;
  logic [VC_W-1:0]   credit_vc_reg;
  logic              err_reg;

  for (genvar gi = 0; gi < NUM_VCS; gi++) begin : g_vc
    vc_fifo #(
      .DEPTH (DEPTH),
      .FLIT_W(FLIT_W)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push[gi]),
      .push_flit(in_flit),
      .pop      (fifo_pop[gi]),
      .full     (fifo_full[gi]),
      .empty    (fifo_empty[gi]),
      .count    (fifo_count[gi]),
      .front    (fifo_front[gi])
    );

    assign fifo_push[gi]    = in_valid && (in_vc == VC_W'(gi));
    assign head_front[gi]   = is_head(flit_type_e'(fifo_front[gi][FLIT_W-1 -: TYPE_W]));
    assign tail_front[gi]   = is_tail(flit_type_e'(fifo_front[gi][FLIT_W-1 -: TYPE_W]));
    assign bad_dest[gi]     = 32'(fifo_front[gi][OUT_W-1:0]) >= NUM_OUTS;
    assign requesting[gi]   = (state_reg[gi] == VC_ACTIVE) && (fifo_count[gi] != '0);
    // Orphan body/tail flits at the front of an idle VC are thrown away.
    assign discard_cand[gi] = (state_reg[gi] == VC_IDLE) && !fifo_empty[gi] && !head_front[gi];

    for (genvar go = 0; go < NUM_OUTS; go++) begin : g_out
      assign sa_req[gi*NUM_OUTS+go] = requesting[gi] && (route_reg[gi] == OUT_W'(go));
    end
  end

  // Lowest set grant bit wins; anything else on the grant bus is a protocol error.
  always_comb begin
    grant_any = 1'b0;
    grant_vc  = '0;
    for (int v = NUM_VCS - 1; v >= 0; v--) begin
      if (sa_grant[v]) begin
        grant_any = 1'b1;
        grant_vc  = VC_W'(v);
      end
    end
    grant_multi = (sa_grant & (sa_grant - 1'b1)) != '0;
    grant_pop   = grant_any && requesting[grant_vc];
    grant_bad   = grant_any && !requesting[grant_vc];
  end

  // Only one credit can leave per cycle, so discards wait for a cycle without a granted pop.
  always_comb begin
    pop_any   = 1'b0;
    pop_vc    = '0;
    route_err = 1'b0;
    if (grant_pop) begin
      pop_any = 1'b1;
      pop_vc  = grant_vc;
    end else begin
      for (int v = NUM_VCS - 1; v >= 0; v--) begin
        if (discard_cand[v]) begin
          pop_any = 1'b1;
          pop_vc  = VC_W'(v);
        end
      end
    end

    for (int v = 0; v < NUM_VCS; v++) begin
      state_next[v] = state_reg[v];
      route_next[v] = route_reg[v];
      fifo_pop[v]   = pop_any && (pop_vc == VC_W'(v));
      case (state_reg[v])
        VC_IDLE: begin
          if (!fifo_empty[v] && head_front[v]) begin
            state_next[v] = VC_ROUTE;
            route_next[v] = bad_dest[v] ? '0 : fifo_front[v][OUT_W-1:0];
            route_err     = route_err | bad_dest[v];
          end
        end
        VC_ROUTE: state_next[v] = VC_ACTIVE;
        VC_ACTIVE: begin
          if (grant_pop && (grant_vc == VC_W'(v)) && tail_front[v]) state_next[v] = VC_IDLE;
        end
        default: state_next[v] = VC_IDLE;
      endcase
    end
  end

  assign drop_any = |(fifo_push & fifo_full & ~fifo_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        state_reg[v] <= VC_IDLE;
        route_reg[v] <= '0;
      end
      out_valid_reg    <= 1'b0;
      out_port_reg     <= '0;
      out_flit_reg     <= '0;
      credit_valid_reg <= 1'b0;
      credit_vc_reg    <= '0;
      err_reg          <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        state_reg[v] <= state_next[v];
        route_reg[v] <= route_next[v];
      end
      out_valid_reg    <= grant_pop;
      out_port_reg     <= grant_pop ? route_reg[grant_vc] : '0;
      out_flit_reg     <= grant_pop ? fifo_front[grant_vc] : '0;
      credit_valid_reg <= pop_any;
      credit_vc_reg    <= pop_any ? pop_vc : '0;
      if (drop_any || route_err || grant_multi || grant_bad || (pop_any && !grant_pop))
        err_reg <= 1'b1;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_port     = out_port_reg;
  assign out_flit     = out_flit_reg;
  assign credit_valid = credit_valid_reg;
  assign credit_vc    = credit_vc_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_input_vc_unit.sv
// Directed bench for input_vc_unit (2 VCs, 3 outputs, depth 4): routing, dequeue, credits and errors.
module tb_input_vc_unit;
  import vcr_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_vc;
  logic [31:0] in_flit;
  logic [5:0]  sa_req;
  logic [1:0]  sa_grant;
  logic        out_valid;
  logic [1:0]  out_port;
  logic [31:0] out_flit;
  logic        credit_valid;
  logic        credit_vc;
  logic        err;

  int vectors;
  int miscompares;

  input_vc_unit #(
    .NUM_VCS (2),
    .NUM_OUTS(3),
    .DEPTH   (4),
    .FLIT_W  (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_vc       (in_vc),
    .in_flit     (in_flit),
    .sa_req      (sa_req),
    .sa_grant    (sa_grant),
    .out_valid   (out_valid),
    .out_port    (out_port),
    .out_flit    (out_flit),
    .credit_valid(credit_valid),
    .credit_vc   (credit_vc),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [27:0] pl, input logic [1:0] d);
    return {t, pl, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      $display("ok   %-22s observed %0h", tag, obs);
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; results are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_vc    = 1'b0;
    in_flit  = '0;
    sa_grant = '0;
    step();
    step();
    reset = 1'b0;
    #2;
  endtask

  task automatic write(input logic vc, input logic [31:0] f);
    in_valid = 1'b1;
    in_vc    = vc;
    in_flit  = f;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] f_a, f_h, f_b, f_t, f_x;
  logic [31:0] seq [4];
  int credits;

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset state
    do_reset();
    chk("rst_sa_req",    32'(sa_req), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_flit",  out_flit, 32'h0);
    chk("rst_credit",    32'(credit_valid), 32'h0);
    chk("rst_err",       32'(err), 32'h0);

    // 1: single HEAD_TAIL to VC0, dest 2
    f_a = mk(FLIT_HEAD_TAIL, 28'h00000A1, 2'd2);
    write(1'b0, f_a);
    chk("t1_idle_req",  32'(sa_req), 32'h0);
    step();
    chk("t1_route_req", 32'(sa_req), 32'h0);
    step();
    chk("t1_active_req", 32'(sa_req), 32'b000100);
    step();
    chk("t1_req_held", 32'(sa_req), 32'b000100);
    sa_grant = 2'b01;
    step();
    sa_grant = 2'b00;
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_out_port",  32'(out_port), 32'd2);
    chk("t1_out_flit",  out_flit, f_a);
    chk("t1_credit",    32'(credit_valid), 32'h1);
    chk("t1_credit_vc", 32'(credit_vc), 32'h0);
    chk("t1_req_after", 32'(sa_req), 32'h0);
    step();
    chk("t1_pulse_ov",  32'(out_valid), 32'h0);
    chk("t1_pulse_cr",  32'(credit_valid), 32'h0);
    chk("t1_err",       32'(err), 32'h0);

    // 2: three-flit packet on VC1, dest 1, granted back to back
    seq[0] = mk(FLIT_HEAD, 28'h0000B01, 2'd1);
    seq[1] = mk(FLIT_BODY, 28'h0000B02, 2'd3);
    seq[2] = mk(FLIT_TAIL, 28'h0000B03, 2'd0);
    for (int i = 0; i < 3; i++) write(1'b1, seq[i]);
    chk("t2_req", 32'(sa_req), 32'b010000);
    sa_grant = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t2_ov_%0d", i),   32'(out_valid), 32'h1);
      chk($sformatf("t2_port_%0d", i), 32'(out_port), 32'd1);
      chk($sformatf("t2_flit_%0d", i), out_flit, seq[i]);
      chk($sformatf("t2_cvc_%0d", i),  32'({credit_valid, credit_vc}), 32'b11);
    end
    sa_grant = 2'b00;
    chk("t2_idle_req", 32'(sa_req), 32'h0);
    step();
    chk("t2_ov_end", 32'(out_valid), 32'h0);
    chk("t2_err",    32'(err), 32'h0);

    // 3: overflow VC0 by one, then drain
    do_reset();
    seq[0] = mk(FLIT_HEAD, 28'h0000C01, 2'd0);
    seq[1] = mk(FLIT_BODY, 28'h0000C02, 2'd0);
    seq[2] = mk(FLIT_BODY, 28'h0000C03, 2'd0);
    seq[3] = mk(FLIT_TAIL, 28'h0000C04, 2'd0);
    f_x    = mk(FLIT_HEAD_TAIL, 28'h0000CFF, 2'd1);
    for (int i = 0; i < 4; i++) write(1'b0, seq[i]);
    chk("t3_err_before", 32'(err), 32'h0);
    write(1'b0, f_x);
    chk("t3_err_drop", 32'(err), 32'h1);
    chk("t3_no_credit", 32'(credit_valid), 32'h0);
    credits = 0;
    sa_grant = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      if (credit_valid) credits++;
      chk($sformatf("t3_flit_%0d", i), out_flit, seq[i]);
    end
    sa_grant = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      if (credit_valid) credits++;
    end
    chk("t3_credits", 32'(credits), 32'd4);
    chk("t3_no_ghost_req", 32'(sa_req), 32'h0);

    // 4: multi-grant and grant to an idle VC
    do_reset();
    f_a = mk(FLIT_HEAD_TAIL, 28'h0000D01, 2'd0);
    f_b = mk(FLIT_HEAD_TAIL, 28'h0000D02, 2'd2);
    write(1'b0, f_a);
    write(1'b1, f_b);
    step();
    step();
    chk("t4_req_both", 32'(sa_req), 32'b100001);
    sa_grant = 2'b11;
    step();
    sa_grant = 2'b00;
    chk("t4_ov", 32'(out_valid), 32'h1);
    chk("t4_flit_vc0", out_flit, f_a);
    chk("t4_credit_vc", 32'(credit_vc), 32'h0);
    chk("t4_err_multi", 32'(err), 32'h1);
    chk("t4_req_vc1", 32'(sa_req), 32'b100000);
    sa_grant = 2'b01;
    step();
    sa_grant = 2'b00;
    chk("t4_idle_grant_ov", 32'(out_valid), 32'h0);
    chk("t4_idle_grant_cr", 32'(credit_valid), 32'h0);
    chk("t4_req_kept", 32'(sa_req), 32'b100000);
    sa_grant = 2'b10;
    step();
    sa_grant = 2'b00;
    chk("t4_vc1_port", 32'(out_port), 32'd2);
    chk("t4_vc1_flit", out_flit, f_b);

    // 5: orphan BODY flit is discarded with a credit
    do_reset();
    write(1'b0, mk(FLIT_BODY, 28'h0000E01, 2'd1));
    chk("t5_err_pre", 32'(err), 32'h0);
    step();
    chk("t5_credit", 32'({credit_valid, credit_vc}), 32'b10);
    chk("t5_err", 32'(err), 32'h1);
    chk("t5_ov", 32'(out_valid), 32'h0);
    chk("t5_req", 32'(sa_req), 32'h0);
    step();
    chk("t5_credit_once", 32'(credit_valid), 32'h0);

    // 6: asynchronous reset mid-packet
    do_reset();
    f_h = mk(FLIT_HEAD, 28'h0000F01, 2'd1);
    write(1'b0, f_h);
    write(1'b0, mk(FLIT_BODY, 28'h0000F02, 2'd0));
    write(1'b0, mk(FLIT_BODY, 28'h0000F03, 2'd0));
    sa_grant = 2'b01;
    step();
    sa_grant = 2'b00;
    chk("t6_ov_pre", 32'(out_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_ov",  32'(out_valid), 32'h0);
    chk("t6_async_cr",  32'(credit_valid), 32'h0);
    chk("t6_async_flit", out_flit, 32'h0);
    chk("t6_async_req", 32'(sa_req), 32'h0);
    step();
    reset = 1'b0;
    #2;
    f_t = mk(FLIT_HEAD_TAIL, 28'h0000F10, 2'd2);
    write(1'b0, f_t);
    step();
    step();
    chk("t6_new_req", 32'(sa_req), 32'b000100);
    chk("t6_err", 32'(err), 32'h0);
    sa_grant = 2'b01;
    step();
    sa_grant = 2'b00;
    chk("t6_new_flit", out_flit, f_t);
    chk("t6_new_port", 32'(out_port), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
